// File: rtl/vga_pkg.sv
// Shared definitions for the VGA scanout path.
// Holds the pixel-format codes used on cfg_mode and the default 640x400@70
// timing, so the scanout top and later overlay blocks agree on both.
package vga_pkg;

   localparam logic [1:0] MODE_RGB332 = 2'd0;
   localparam logic [1:0] MODE_RGB565 = 2'd1;
   localparam logic [1:0] MODE_GRAY8  = 2'd2;

   localparam int DEF_H   = 640;
   localparam int DEF_HFP = 16;
   localparam int DEF_HS  = 96;
   localparam int DEF_HBP = 48;
   localparam int DEF_V   = 400;
   localparam int DEF_VFP = 12;
   localparam int DEF_VS  = 2;
   localparam int DEF_VBP = 35;

   localparam bit DEF_HS_POL = 1'b0;
   localparam bit DEF_VS_POL = 1'b1;

endpackage

// File: rtl/vga_pix_expand.sv
// Combinational pixel-format decode: one framebuffer word to 8-bit R/G/B.
// Narrow channels are widened by repeating their top bits, so full scale
// maps to 0xFF. The reserved mode code decodes as RGB332.
// Ports:
//   mode  in  2   pixel format code (vga_pkg MODE_*)
//   data  in  16  framebuffer word
//   r/g/b out 8   expanded colour
module vga_pix_expand
   import vga_pkg::*;
(
   input  logic [1:0]  mode,
   input  logic [15:0] data,
   output logic [7:0]  r,
   output logic [7:0]  g,
   output logic [7:0]  b
);

   always_comb begin
      r = {data[7:5], data[7:5], data[7:6]};
      g = {data[4:2], data[4:2], data[4:3]};
      b = {4{data[1:0]}};
      case (mode)
         MODE_RGB565: begin
            r = {data[15:11], data[15:13]};
            g = {data[10:5], data[10:9]};
            b = {data[4:0], data[4:2]};
         end
         MODE_GRAY8: begin
            r = data[7:0];
            g = data[7:0];
            b = data[7:0];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/vga_scanout.sv
// Programmable-timing VGA scanout with framebuffer fetch.
// Raw h/v counters generate sync/blank/visible; visible cycles issue a read
// at line_addr + x_idx with integer X/Y pixel repetition. Sync and blank
// flags are delayed RD_LAT+1 cycles to line up with the registered colour.
// Base address and pixel mode are captured at the start of vertical blank,
// so page flips are tear-free; stride is used live.
// Ports:
//   pclk, reset            pixel clock, synchronous active-high reset
//   cfg_base/stride/mode   frame base, line increment, pixel format
//   mem_rd/mem_addr/data   framebuffer read port (data RD_LAT cycles later)
//   hs, vs, hblank, vblank, de, r, g, b, frame_start   video output
module vga_scanout
   import vga_pkg::*;
#(
   parameter int H       = DEF_H,
   parameter int HFP     = DEF_HFP,
   parameter int HS      = DEF_HS,
   parameter int HBP     = DEF_HBP,
   parameter int V       = DEF_V,
   parameter int VFP     = DEF_VFP,
   parameter int VS      = DEF_VS,
   parameter int VBP     = DEF_VBP,
   parameter bit HS_POL  = DEF_HS_POL,
   parameter bit VS_POL  = DEF_VS_POL,
   parameter int XSCALE  = 4,
   parameter int YSCALE  = 4,
   parameter int AW      = 18,
   parameter int DW      = 16,
   parameter int RD_LAT  = 1
) (
   input  logic          pclk,
   input  logic          reset,
   input  logic [AW-1:0] cfg_base,
   input  logic [AW-1:0] cfg_stride,
   input  logic [1:0]    cfg_mode,
   output logic          mem_rd,
   output logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_data,
   output logic          hs,
   output logic          vs,
   output logic          hblank,
   output logic          vblank,
   output logic          de,
   output logic [7:0]    r,
   output logic [7:0]    g,
   output logic [7:0]    b,
   output logic          frame_start
);

   localparam int HT  = H + HFP + HS + HBP;
   localparam int VT  = V + VFP + VS + VBP;
   // One spare bit so every timing boundary, including HT/VT, is representable.
   localparam int HCW = $clog2(HT + 1);
   localparam int VCW = $clog2(VT + 1);
   localparam int XSW = (XSCALE > 1) ? $clog2(XSCALE) : 1;
   localparam int YSW = (YSCALE > 1) ? $clog2(YSCALE) : 1;
   localparam int XIW = $clog2(H / XSCALE + 1);
   localparam int PD  = RD_LAT + 1;

   logic [HCW-1:0] h_cnt;
   logic [VCW-1:0] v_cnt;
   logic           h_last, v_last;
   logic           vis_raw, hs_raw, vs_raw, hb_raw, vb_raw, fs_raw;

   assign h_last = (h_cnt == HCW'(HT - 1));
   assign v_last = (v_cnt == VCW'(VT - 1));

   // Reset parks at the first blank line so the first frame latches its config.
   always_ff @(posedge pclk) begin
      if (reset) begin
         h_cnt <= '0;
         v_cnt <= VCW'(V);
      end else if (h_last) begin
         h_cnt <= '0;
         v_cnt <= v_last ? '0 : v_cnt + VCW'(1);
      end else begin
         h_cnt <= h_cnt + HCW'(1);
      end
   end

   assign hb_raw  = (h_cnt >= HCW'(H));
   assign vb_raw  = (v_cnt >= VCW'(V));
   assign vis_raw = !hb_raw && !vb_raw;
   assign hs_raw  = (h_cnt >= HCW'(H + HFP) && h_cnt < HCW'(H + HFP + HS)) ? HS_POL : !HS_POL;
   assign vs_raw  = (v_cnt >= VCW'(V + VFP) && v_cnt < VCW'(V + VFP + VS)) ? VS_POL : !VS_POL;
   assign fs_raw  = (h_cnt == '0) && (v_cnt == '0);

   logic [XSW-1:0] x_sub;
   logic [XIW-1:0] x_idx;
   logic [YSW-1:0] y_sub;
   logic [AW-1:0]  line_addr;
   logic [1:0]     mode_lat;

   always_ff @(posedge pclk) begin
      if (reset) begin
         x_sub     <= '0;
         x_idx     <= '0;
         y_sub     <= '0;
         line_addr <= '0;
         mode_lat  <= MODE_RGB332;
      end else begin
         // x_idx is held at 0 through blanking so it is already 0 at h=0.
         if (vis_raw) begin
            if (x_sub == XSW'(XSCALE - 1)) begin
               x_sub <= '0;
               x_idx <= x_idx + XIW'(1);
            end else begin
               x_sub <= x_sub + XSW'(1);
            end
         end else begin
            x_sub <= '0;
            x_idx <= '0;
         end

         if (vis_raw && h_cnt == HCW'(H - 1)) begin
            if (y_sub == YSW'(YSCALE - 1)) begin
               y_sub     <= '0;
               line_addr <= line_addr + cfg_stride;
            end else begin
               y_sub <= y_sub + YSW'(1);
            end
         end

         if (h_cnt == '0 && v_cnt == VCW'(V)) begin
            line_addr <= cfg_base;
            mode_lat  <= cfg_mode;
            y_sub     <= '0;
         end
      end
   end

   assign mem_rd   = vis_raw && !reset;
   assign mem_addr = line_addr + AW'(x_idx);

   // Bit k of each delay line holds the raw flag from k+1 cycles ago.
   logic [PD-1:0] vis_d, hs_d, vs_d, hb_d, vb_d, fs_d;

   always_ff @(posedge pclk) begin
      if (reset) begin
         vis_d <= '0;
         hs_d  <= {PD{!HS_POL}};
         vs_d  <= {PD{!VS_POL}};
         hb_d  <= '1;
         vb_d  <= '1;
         fs_d  <= '0;
      end else begin
         vis_d <= {vis_d[PD-2:0], vis_raw};
         hs_d  <= {hs_d[PD-2:0], hs_raw};
         vs_d  <= {vs_d[PD-2:0], vs_raw};
         hb_d  <= {hb_d[PD-2:0], hb_raw};
         vb_d  <= {vb_d[PD-2:0], vb_raw};
         fs_d  <= {fs_d[PD-2:0], fs_raw};
      end
   end

   logic [7:0] r_exp, g_exp, b_exp;

   vga_pix_expand u_pix_expand (
      .mode (mode_lat),
      .data (mem_data[15:0]),
      .r    (r_exp),
      .g    (g_exp),
      .b    (b_exp)
   );

   // mem_data for a read issued RD_LAT cycles ago is present now.
   always_ff @(posedge pclk) begin
      if (reset) begin
         {r, g, b} <= 24'd0;
      end else begin
         {r, g, b} <= vis_d[RD_LAT-1] ? {r_exp, g_exp, b_exp} : 24'd0;
      end
   end

   assign de          = vis_d[PD-1];
   assign hs          = hs_d[PD-1];
   assign vs          = vs_d[PD-1];
   assign hblank      = hb_d[PD-1];
   assign vblank      = vb_d[PD-1];
   assign frame_start = fs_d[PD-1];

endmodule

// File: tb/tb_vga_scanout.sv
module tb_vga_scanout;

   localparam int H = 8, HFP = 2, HSW = 2, HBP = 2;
   localparam int V = 4, VFP = 1, VSW = 1, VBP = 1;
   localparam int XS = 2, YS = 2, AW = 18, DW = 16, RDL = 2;
   localparam bit HS_POL = 1'b0, VS_POL = 1'b1;
   localparam int HT = H + HFP + HSW + HBP;
   localparam int VT = V + VFP + VSW + VBP;
   localparam int F0 = (VT - V) * HT + RDL + 1;

   logic          pclk = 1'b0;
   logic          reset = 1'b1;
   logic [AW-1:0] cfg_base = '0;
   logic [AW-1:0] cfg_stride = '0;
   logic [1:0]    cfg_mode = 2'd0;
   logic          mem_rd;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data;
   logic [DW-1:0] mem_q1;
   logic          hs, vs, hblank, vblank, de, frame_start;
   logic [7:0]    r, g, b;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   logic [AW-1:0] base_m = '0;
   logic [1:0]    mode_m = 2'd0;
   logic          fixed_en = 1'b0;
   logic [15:0]   fixed_val = 16'h0;
   logic [15:0]   salt = 16'h1234;

   typedef struct packed {
      logic de, hs, vs, hb, vb, fs;
      logic [7:0] r, g, b;
   } exp_t;
   exp_t q[$];

   vga_scanout #(
      .H(H), .HFP(HFP), .HS(HSW), .HBP(HBP),
      .V(V), .VFP(VFP), .VS(VSW), .VBP(VBP),
      .HS_POL(HS_POL), .VS_POL(VS_POL),
      .XSCALE(XS), .YSCALE(YS), .AW(AW), .DW(DW), .RD_LAT(RDL)
   ) dut (
      .pclk(pclk), .reset(reset),
      .cfg_base(cfg_base), .cfg_stride(cfg_stride), .cfg_mode(cfg_mode),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
      .hs(hs), .vs(vs), .hblank(hblank), .vblank(vblank), .de(de),
      .r(r), .g(g), .b(b), .frame_start(frame_start)
   );

   always #5 pclk = ~pclk;

   function automatic logic [15:0] memf(logic [AW-1:0] a);
      logic [31:0] t;
      if (fixed_en) return fixed_val;
      t = {14'd0, a} * 32'h9E3779B1;
      return t[31:16] ^ salt ^ a[15:0];
   endfunction

   // Framebuffer: one registered read plus one extra register stage.
   always @(posedge pclk) begin
      mem_q1   <= memf(mem_addr);
      mem_data <= mem_q1;
   end

   function automatic logic [23:0] expand(logic [15:0] d, logic [1:0] m);
      int rr, gg, bb, c;
      case (m)
         2'd1: begin
            rr = int'(d[15:11]); gg = int'(d[10:5]); bb = int'(d[4:0]);
            rr = (rr << 3) | (rr >> 2);
            gg = (gg << 2) | (gg >> 4);
            bb = (bb << 3) | (bb >> 2);
         end
         2'd2: begin
            rr = int'(d[7:0]); gg = rr; bb = rr;
         end
         default: begin
            c  = int'(d[7:5]); rr = (c << 5) | (c << 2) | (c >> 1);
            c  = int'(d[4:2]); gg = (c << 5) | (c << 2) | (c >> 1);
            c  = int'(d[1:0]); bb = c * 85;
         end
      endcase
      return {rr[7:0], gg[7:0], bb[7:0]};
   endfunction

   function automatic int ph(int c);
      return c % HT;
   endfunction

   function automatic int pv(int c);
      return (c / HT + V) % VT;
   endfunction

   function automatic exp_t rst_entry();
      exp_t e;
      e = '0;
      e.hs = !HS_POL; e.vs = !VS_POL; e.hb = 1'b1; e.vb = 1'b1;
      return e;
   endfunction

   task automatic reload_q();
      q.delete();
      repeat (RDL + 1) q.push_back(rst_entry());
   endtask

   // One pixel clock: checks the read port against the raw position and the
   // video outputs against the expectation queued RD_LAT+1 cycles earlier.
   task automatic tick(input string tag);
      int h, v;
      logic vis;
      logic [AW-1:0] a;
      logic [23:0] rgb;
      exp_t e, o;
      @(negedge pclk);
      h = ph(cyc);
      v = pv(cyc);
      if (h == 0 && v == V) begin
         base_m = cfg_base;
         mode_m = cfg_mode;
      end
      vis = (h < H) && (v < V);
      a = AW'(int'(base_m) + (v / YS) * int'(cfg_stride) + h / XS);
      checks++;
      if (mem_rd !== vis) begin
         errors++;
         $display("FAIL %s mem_rd c=%0d h=%0d v=%0d got=%b exp=%b", tag, cyc, h, v, mem_rd, vis);
      end
      if (vis) begin
         checks++;
         if (mem_addr !== a) begin
            errors++;
            $display("FAIL %s mem_addr c=%0d h=%0d v=%0d got=%h exp=%h", tag, cyc, h, v, mem_addr, a);
         end
      end
      e.de = vis;
      e.hs = (h >= H + HFP && h < H + HFP + HSW) ? HS_POL : !HS_POL;
      e.vs = (v >= V + VFP && v < V + VFP + VSW) ? VS_POL : !VS_POL;
      e.hb = (h >= H);
      e.vb = (v >= V);
      e.fs = (h == 0 && v == 0);
      rgb = vis ? expand(memf(a), mode_m) : 24'd0;
      e.r = rgb[23:16]; e.g = rgb[15:8]; e.b = rgb[7:0];
      q.push_back(e);
      o = q.pop_front();
      checks++;
      if ({de, hs, vs, hblank, vblank, frame_start} !== {o.de, o.hs, o.vs, o.hb, o.vb, o.fs}) begin
         errors++;
         $display("FAIL %s sync c=%0d got(de,hs,vs,hb,vb,fs)=%b exp=%b", tag, cyc,
                  {de, hs, vs, hblank, vblank, frame_start}, {o.de, o.hs, o.vs, o.hb, o.vb, o.fs});
      end
      checks++;
      if ({r, g, b} !== {o.r, o.g, o.b}) begin
         errors++;
         $display("FAIL %s rgb c=%0d got=%h exp=%h", tag, cyc, {r, g, b}, {o.r, o.g, o.b});
      end
      @(posedge pclk);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int h, input int v);
      int guard;
      guard = 0;
      while (!(ph(cyc) == h && pv(cyc) == v) && guard < HT * VT) begin
         tick("run");
         guard++;
      end
   endtask

   // Late in the last visible line, after all in-flight reads have landed.
   task automatic run_to_prep();
      run_to(H + RDL + 2, V - 1);
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      #1;
      checks++;
      if (mem_rd !== 1'b0) begin
         errors++;
         $display("FAIL reset_mem_rd got=%b exp=0", mem_rd);
      end
      @(posedge pclk);
      #1;
      checks++;
      if ({mem_rd, hs, vs, hblank, vblank, de, frame_start, r, g, b} !==
          {1'b0, !HS_POL, !VS_POL, 1'b1, 1'b1, 1'b0, 1'b0, 24'd0}) begin
         errors++;
         $display("FAIL reset_outputs got(rd,hs,vs,hb,vb,de,fs)=%b rgb=%h exp=%b rgb=000000",
                  {mem_rd, hs, vs, hblank, vblank, de, frame_start}, {r, g, b},
                  {1'b0, !HS_POL, !VS_POL, 1'b1, 1'b1, 1'b0, 1'b0});
      end
      repeat (n - 1) @(posedge pclk);
      #1;
      reset = 1'b0;
      cyc = 0;
      reload_q();
   endtask

   task automatic test_reset();
      cfg_base   = 18'h100;
      cfg_stride = 18'h10;
      cfg_mode   = 2'd0;
      do_reset(3);
   endtask

   task automatic test_timing();
      int fs_cyc[$];
      int n_de, n_hs, n_vs, first_hs, first_vs;
      n_de = 0; n_hs = 0; n_vs = 0; first_hs = -1; first_vs = -1;
      for (int i = 0; i < 2 * HT * VT; i++) begin
         if (frame_start === 1'b1) fs_cyc.push_back(cyc);
         if (cyc >= F0 && cyc < F0 + 98) begin
            if (de === 1'b1) n_de++;
            if (hs === HS_POL) begin
               n_hs++;
               if (first_hs < 0) first_hs = cyc;
            end
            if (vs === VS_POL) begin
               n_vs++;
               if (first_vs < 0) first_vs = cyc;
            end
         end
         tick("timing");
      end
      checks++;
      if (fs_cyc.size() != 2 || fs_cyc[0] != F0 || fs_cyc[1] != F0 + 98) begin
         errors++;
         $display("FAIL frame_period pulses=%0d first=%0d second=%0d exp 2 at %0d and %0d",
                  fs_cyc.size(), (fs_cyc.size() > 0) ? fs_cyc[0] : -1,
                  (fs_cyc.size() > 1) ? fs_cyc[1] : -1, F0, F0 + 98);
      end
      checks++;
      if (n_de != 32) begin errors++; $display("FAIL de_count got=%0d exp=32", n_de); end
      checks++;
      if (n_hs != 14) begin errors++; $display("FAIL hs_count got=%0d exp=14", n_hs); end
      checks++;
      if (n_vs != 14) begin errors++; $display("FAIL vs_count got=%0d exp=14", n_vs); end
      checks++;
      if (first_hs != F0 + 10) begin errors++; $display("FAIL hs_edge got=%0d exp=%0d", first_hs, F0 + 10); end
      checks++;
      if (first_vs != F0 + 5 * 14) begin errors++; $display("FAIL vs_edge got=%0d exp=%0d", first_vs, F0 + 70); end
   endtask

   task automatic test_scaling();
      logic [AW-1:0] got[$];
      logic [AW-1:0] exp_a;
      run_to_prep();
      cfg_base   = 18'h100;
      cfg_stride = 18'h10;
      run_to(0, 0);
      for (int i = 0; i < V * HT; i++) begin
         if (mem_rd === 1'b1) got.push_back(mem_addr);
         tick("scale");
      end
      checks++;
      if (got.size() != H * V) begin
         errors++;
         $display("FAIL scale_count got=%0d exp=%0d", got.size(), H * V);
      end
      for (int i = 0; i < got.size() && i < H * V; i++) begin
         exp_a = AW'(32'h100 + (i / H / YS) * 32'h10 + (i % H) / XS);
         checks++;
         if (got[i] !== exp_a) begin
            errors++;
            $display("FAIL scale_addr idx=%0d got=%h exp=%h", i, got[i], exp_a);
         end
      end
   endtask

   task automatic test_formats();
      logic [15:0] vals[4]  = '{16'h00E3, 16'hF800, 16'h0055, 16'h00E3};
      logic [1:0]  modes[4] = '{2'd0, 2'd1, 2'd2, 2'd3};
      logic [23:0] exps[4]  = '{24'hFF00FF, 24'hFF0000, 24'h555555, 24'hFF00FF};
      for (int k = 0; k < 4; k++) begin
         run_to_prep();
         cfg_mode  = modes[k];
         fixed_en  = 1'b1;
         fixed_val = vals[k];
         run_to(RDL + 1, 0);
         checks++;
         if ({de, frame_start, r, g, b} !== {1'b1, 1'b1, exps[k]}) begin
            errors++;
            $display("FAIL format mode=%0d data=%h got de=%b fs=%b rgb=%h exp de=1 fs=1 rgb=%h",
                     modes[k], vals[k], de, frame_start, {r, g, b}, exps[k]);
         end
         run_to(0, 1);
      end
      run_to_prep();
      fixed_en = 1'b0;
      cfg_mode = 2'd1;
   endtask

   task automatic test_page_flip();
      run_to_prep();
      cfg_base   = 18'h100;
      cfg_stride = 18'h10;
      run_to(0, 0);
      run_to(0, 1);
      cfg_base = 18'h200;
      for (int i = 0; i < (V - 1) * HT; i++) begin
         if (mem_rd === 1'b1) begin
            checks++;
            if (mem_addr[AW-1:8] !== 10'h001) begin
               errors++;
               $display("FAIL flip_current c=%0d got=%h exp=1xx", cyc, mem_addr);
            end
         end
         tick("flip");
      end
      run_to(0, 0);
      checks++;
      if (mem_rd !== 1'b1 || mem_addr !== 18'h200) begin
         errors++;
         $display("FAIL flip_next got rd=%b addr=%h exp rd=1 addr=00200", mem_rd, mem_addr);
      end
      tick("flip");
   endtask

   task automatic test_reset_mid();
      int found;
      run_to(0, 0);
      run_to(3, 2);
      do_reset(2);
      found = -1;
      for (int i = 0; i < 2 * HT * VT && found < 0; i++) begin
         if (frame_start === 1'b1) found = cyc;
         tick("rstmid");
      end
      checks++;
      if (found != F0) begin
         errors++;
         $display("FAIL rstmid_frame_start got=%0d exp=%0d", found, F0);
      end
      checks++;
      if (frame_start !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_pulse_width got=%b exp=0", frame_start);
      end
   endtask

   task automatic test_wrap();
      logic [AW-1:0] got[$];
      logic [AW-1:0] exp_l0[8] = '{18'h3FFFE, 18'h3FFFE, 18'h3FFFF, 18'h3FFFF,
                                   18'h00000, 18'h00000, 18'h00001, 18'h00001};
      run_to_prep();
      cfg_base   = 18'h3FFFE;
      cfg_stride = 18'h1;
      run_to(0, 0);
      for (int i = 0; i < HT; i++) begin
         if (mem_rd === 1'b1) got.push_back(mem_addr);
         tick("wrap");
      end
      checks++;
      if (got.size() != H) begin
         errors++;
         $display("FAIL wrap_count got=%0d exp=%0d", got.size(), H);
      end
      for (int i = 0; i < got.size() && i < H; i++) begin
         checks++;
         if (got[i] !== exp_l0[i]) begin
            errors++;
            $display("FAIL wrap_addr idx=%0d got=%h exp=%h", i, got[i], exp_l0[i]);
         end
      end
      run_to(0, 0);
   endtask

   task automatic test_random();
      for (int f = 0; f < 4; f++) begin
         run_to_prep();
         cfg_base   = AW'($urandom);
         cfg_stride = AW'($urandom_range(0, 1023));
         cfg_mode   = 2'($urandom_range(0, 3));
         salt       = 16'($urandom);
         run_to(0, 0);
         for (int i = 0; i < HT * VT; i++) tick("random");
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_timing();
      test_scaling();
      test_formats();
      test_page_flip();
      test_reset_mid();
      test_wrap();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
